uart_block_sender: RTL
======================

// Module: uart_block_sender
// PURPOSE
//  Shares the single byte-wide UART transmitter between two block producers
//  (e.g. SM4 ciphertext path and debug/status path). Each producer offers a
//  DATA_BYTES-wide word. The block arbitrates between them round-robin and
//  serialises the granted word MSB byte first. It drives the transmitter's
//  level-held enable / send_ok handshake and sits between the producers and
//  the UART tx instance.
// PARAMETERS
//  DATA_BYTES  16  bytes per request word; 128-bit SM4 block; legal range 1..32
// PORTS
//  sys_clk      in   1             system clock; all logic on rising edge
//  sys_rst      in   1             reset, asynchronous, active-high
//  req0_valid   in   1             producer 0 has a word; held until req0_ready
//  req0_data    in   8*DATA_BYTES   producer 0 word; stable while req0_valid
//  req0_ready   out  1             1-cycle pulse: word 0 captured
//  req1_valid   in   1             producer 1 valid, same rules
//  req1_data    in   8*DATA_BYTES   producer 1 word
//  req1_ready   out  1             1-cycle pulse: word 1 captured
//  tx_en        out  1             to UART tx enable; held high per byte
//  tx_data      out  8             to UART tx data; stable while tx_en=1
//  tx_done      in   1             UART tx send_ok; high until tx_en drops
//  busy         out  1             high in any state other than IDLE
//  grant        out  1             requester owning the current word (0/1)
//  blk_done     out  1             1-cycle pulse after last byte acknowledged
// BEHAVIOUR
//  Reset values: req*_ready=0, tx_en=0, tx_data=0, busy=0, grant=0, blk_done=0.
//   RR pointer favours req0.
//  FSM states: IDLE, SEND, GAP.
//  IDLE:
//   - If any valid, grant by RR; sole requester always wins.
//   - Load word into shift reg and byte counter=DATA_BYTES-1.
//   - Pulse matching ready for that cycle, set grant, toggle RR pointer to
//     the loser.
//   - Next state SEND.
//  SEND:
//   - tx_en=1, tx_data=shift[top byte].
//   - Stay until tx_done=1, then go to GAP with tx_en=0 registered.
//  GAP:
//   - tx_en=0. Wait until tx_done=0; the UART clears send_ok only with enable
//     low, so at least 1 cycle low is mandatory.
//   - If counter==0: pulse blk_done, go to IDLE.
//   - Else shift left 8, counter-1, go to SEND.
//  Byte order: bits [8*DATA_BYTES-1 -: 8] go first, bits [7:0] go last.
//  Counter width is $clog2(DATA_BYTES+2). No wrap; counter never underflows.
//  Valid changes while busy are ignored until the FSM returns to IDLE.
//   Words are never dropped or duplicated.
//  Both valid in IDLE: RR decides; the loser is served next block.
//  blk_done and the next grant may not share a cycle. Min 1 IDLE cycle between
//   blocks.
//  tx_done=1 seen in IDLE or GAP-entry: ignored except for the GAP exit rule.
//   No timeout.
//  sys_rst mid-block: all state returns to reset values at once. The partial
//   word is discarded, and the producer must re-offer it. The UART is reset by
//   the same net.
// CONFIGURATION
//  `UART_SENDER_FRAME_EN defined:
//   - Each block becomes SYNC(8'hA5), DATA_BYTES payload bytes, then CHK.
//   - CHK = XOR of all payload bytes, accumulated as each byte is acknowledged.
//   - Counter loads DATA_BYTES+1.
//  Macro undefined: payload only, no sync or checksum logic synthesised.
// STRUCTURE
//  Package uart_ctrl_pkg holds:
//   - state enum {IDLE, SEND, GAP}
//   - localparam SYNC_BYTE = 8'hA5
//   - localparam BYTE_W = 8
//  Sub-module rr_arb2 holds the 2-way round-robin arbiter (valid[1:0] in,
//   grant one-hot out, pointer update on accept). The FSM and shift logic stay
//   in this module.
// TESTING
//  Use a UART tx response model: assert tx_done 5 cycles after tx_en rises, and
//   hold it until tx_en falls.
//  T1: req0 word=128'h0011..EEFF, DATA_BYTES=16 -> tx_data sequence 00,11,..,FF.
//   16 tx_en pulses, one blk_done, grant=0.
//  T2: req0,req1 valid same cycle after reset -> req0 served first, req1 next.
//   Then both again -> req1 first (RR).
//  T3: tx_done held high 3 extra cycles after tx_en falls -> no new tx_en until
//   tx_done=0. No byte skipped.
//  T4: assert sys_rst during byte 7 -> tx_en=0, busy=0 same cycle. After
//   release, re-offered word is sent from byte 0.
//  T5 (FRAME_EN): word of 16 bytes all 8'h01 -> A5, 01 x16, then CHK=00.
//   Word 8'h01..8'h10 -> CHK=8'h10.
//  T6: req1 valid held while req0 block is mid-send -> req1_ready only after
//   blk_done plus 1 IDLE cycle.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART block sender.
// The optional frame mode is enabled by defining UART_SENDER_FRAME_EN.
package uart_ctrl_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; the pointer
// moves to the losing side only when both requesters competed.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  // Pointer value names the favoured requester.
  logic ptr;

  always_comb begin
    // NOTE: default assignment first so no path leaves grant unassigned (no latch).
    grant = valid;
    if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             ptr <= 1'b0;
    else if (accept && valid == 2'b11)   ptr <= grant[0];
  end

endmodule

// File: rtl/uart_block_sender.sv
// Shares one byte-wide UART transmitter between two word producers,
// sending each granted word MSB byte first. Define UART_SENDER_FRAME_EN
// to wrap every block as SYNC, payload, XOR checksum.
module uart_block_sender
  import uart_ctrl_pkg::*;
#(
  parameter int DATA_BYTES = 16
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    req0_valid,
  input  logic [8*DATA_BYTES-1:0] req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [8*DATA_BYTES-1:0] req1_data,
  output logic                    req1_ready,
  output logic                    tx_en,
  output logic [7:0]              tx_data,
  input  logic                    tx_done,
  output logic                    busy,
  output logic                    grant,
  output logic                    blk_done
);

  localparam int WORD_W = BYTE_W * DATA_BYTES;
  localparam int CNT_W  = $clog2(DATA_BYTES + 2);
`ifdef UART_SENDER_FRAME_EN
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_BYTES + 1);
`else
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_BYTES - 1);
`endif

  state_t              state;
  logic [WORD_W-1:0]   shift;
  logic [CNT_W-1:0]    cnt;
  logic [1:0]          arb_grant;
  logic                accept;
  logic [WORD_W-1:0]   word_in;
  logic [WORD_W-1:0]   shift_adv;
  logic [BYTE_W-1:0]   next_byte;
  logic [BYTE_W-1:0]   first_byte;

  assign accept  = (state == IDLE) && (req0_valid || req1_valid);
  assign word_in = arb_grant[1] ? req1_data : req0_data;

  rr_arb2 u_arb (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .valid  ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (arb_grant)
  );

`ifdef UART_SENDER_FRAME_EN
  logic [BYTE_W-1:0] chk;
  logic              sent_payload;

  // The byte on the wire is payload unless it is SYNC (cnt at load) or CHK (cnt zero).
  assign sent_payload = (cnt != '0) && (cnt != CNT_LOAD);
  assign shift_adv    = sent_payload ? (shift << BYTE_W) : shift;
  assign next_byte    = (cnt == CNT_W'(1)) ? chk : shift_adv[WORD_W-1 -: BYTE_W];
  assign first_byte   = SYNC_BYTE;
`else
  assign shift_adv    = shift << BYTE_W;
  assign next_byte    = shift_adv[WORD_W-1 -: BYTE_W];
  assign first_byte   = word_in[WORD_W-1 -: BYTE_W];
`endif

  // NOTE: sequential state uses non-blocking assignments only; every register,
  // including the word shift register, returns to a known value on reset.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      shift      <= '0;
      cnt        <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      tx_en      <= 1'b0;
      tx_data    <= '0;
      busy       <= 1'b0;
      grant      <= 1'b0;
      blk_done   <= 1'b0;
`ifdef UART_SENDER_FRAME_EN
      chk        <= '0;
`endif
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      blk_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shift      <= word_in;
            cnt        <= CNT_LOAD;
            req0_ready <= arb_grant[0];
            req1_ready <= arb_grant[1];
            grant      <= arb_grant[1];
            tx_data    <= first_byte;
            tx_en      <= 1'b1;
            busy       <= 1'b1;
            state      <= SEND;
`ifdef UART_SENDER_FRAME_EN
            chk        <= '0;
`endif
          end
        end
        SEND: begin
          if (tx_done) begin
            tx_en <= 1'b0;
            state <= GAP;
`ifdef UART_SENDER_FRAME_EN
            if (sent_payload) chk <= chk ^ tx_data;
`endif
          end
        end
        GAP: begin
          // The UART releases send_ok only while enable is low.
          if (!tx_done) begin
            if (cnt == '0) begin
              blk_done <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              shift    <= shift_adv;
              cnt      <= cnt - CNT_W'(1);
              tx_data  <= next_byte;
              tx_en    <= 1'b1;
              state    <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
